// File: rtl/sram_port_ctrl_if.sv
// sram_port_ctrl_if: request/acknowledge bundle between the test controller and the SRAM port controller
interface sram_port_ctrl_if;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  modport master (output req, wr, addr, wdata, input rdata, busy, done);
  modport slave  (input req, wr, addr, wdata, output rdata, busy, done);
endinterface

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: single-word read/write sequencer for the asynchronous 16-bit Ram1 SRAM
module sram_port_ctrl #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  sram_port_ctrl_if.slave   host,
  output logic [17:0]       Ram1Addr,
  inout  wire  [15:0]       Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN
);
  typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT} state_t;
  localparam logic [3:0] LOAD = 4'(WAIT_CYCLES - 1);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt;
  logic        w_done, w_cap, w_accept, w_last;
  logic [15:0] r_addr, r_wdata, r_rdata;
  logic        r_en, r_oe, r_we, r_drv, r_busy, r_done;
  assign w_accept = (r_state == IDLE) && host.req;
  assign w_last   = (r_cnt == 4'd0);
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_done = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      IDLE:    w_next = !host.req ? IDLE : host.wr ? W_SETUP : R_SETUP;
      W_SETUP: begin w_next = W_PULSE; w_cnt = LOAD; end
      W_PULSE: begin w_next = w_last ? W_HOLD : W_PULSE; w_cnt = w_last ? r_cnt : r_cnt - 4'd1; end
      W_HOLD:  begin w_next = IDLE; w_done = 1'b1; end
      R_SETUP: begin w_next = R_WAIT; w_cnt = LOAD; end
      R_WAIT:  begin
        w_next = w_last ? IDLE : R_WAIT;
        w_cnt  = w_last ? r_cnt : r_cnt - 4'd1;
        w_done = w_last;
        w_cap  = w_last;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
    end
  end
  // Pin strobes are registered from the next state so every SRAM pin changes only on a clock edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= 16'd0;
      r_wdata <= 16'd0;
      r_rdata <= 16'd0;
      r_en    <= 1'b1;
      r_oe    <= 1'b1;
      r_we    <= 1'b1;
      r_drv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= host.addr;
        r_wdata <= host.wdata;
      end
      if (w_cap) r_rdata <= Ram1Data;
      r_en   <= (w_next == IDLE);
      r_oe   <= !((w_next == R_SETUP) || (w_next == R_WAIT));
      r_we   <= (w_next != W_PULSE);
      r_drv  <= (w_next == W_SETUP) || (w_next == W_PULSE) || (w_next == W_HOLD);
      r_busy <= (w_next != IDLE);
      r_done <= w_done;
    end
  end
  assign Ram1Addr   = {2'b00, r_addr};
  assign Ram1Data   = r_drv ? r_wdata : 16'hzzzz;
  assign Ram1OE     = r_oe;
  assign Ram1WE     = r_we;
  assign Ram1EN     = r_en;
  assign host.rdata = r_rdata;
  assign host.busy  = r_busy;
  assign host.done  = r_done;
endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb_sram_port_ctrl: two controllers (access width 1 and 3) against SRAM models and a word-level reference memory
module tb_sram_port_ctrl;
  logic        CLK = 1'b0, RST = 1'b0, s = 1'b0, probe = 1'b0, req = 1'b0, wr = 1'b0;
  logic [15:0] addr = 16'd0, wdata = 16'd0;
  int          vectors = 0, errors = 0;
  logic [15:0] ref_mem [int];
  logic [15:0] last_rd [2];
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  wire  [15:0] bus_a, bus_b;
  logic [17:0] addr_a, addr_b;
  logic        oe_a, we_a, en_a, oe_b, we_b, en_b;
  always #5 CLK = ~CLK;
  sram_port_ctrl_if ifa();
  sram_port_ctrl_if ifb();
  assign ifa.req = req && !s;
  assign ifa.wr = wr;
  assign ifa.addr = addr;
  assign ifa.wdata = wdata;
  assign ifb.req = req && s;
  assign ifb.wr = wr;
  assign ifb.addr = addr;
  assign ifb.wdata = wdata;
  sram_port_ctrl #(.WAIT_CYCLES(1)) dut_a (.CLK(CLK), .RST(RST), .host(ifa), .Ram1Addr(addr_a),
    .Ram1Data(bus_a), .Ram1OE(oe_a), .Ram1WE(we_a), .Ram1EN(en_a));
  sram_port_ctrl #(.WAIT_CYCLES(3)) dut_b (.CLK(CLK), .RST(RST), .host(ifb), .Ram1Addr(addr_b),
    .Ram1Data(bus_b), .Ram1OE(oe_b), .Ram1WE(we_b), .Ram1EN(en_b));
  // Asynchronous SRAM models; probe pulls an idle bus to zero so a still-driving controller shows up
  assign bus_a = (!en_a && !oe_a) ? mem_a[addr_a[15:0]] : 16'hzzzz;
  assign bus_b = (!en_b && !oe_b) ? mem_b[addr_b[15:0]] : probe ? 16'h0000 : 16'hzzzz;
  always @(posedge CLK) if (!en_a && !we_a) mem_a[addr_a[15:0]] <= bus_a;
  always @(posedge CLK) if (!en_b && !we_b) mem_b[addr_b[15:0]] <= bus_b;
  wire [15:0] m_bus  = s ? bus_b : bus_a;
  wire [17:0] m_addr = s ? addr_b : addr_a;
  wire        m_oe   = s ? oe_b : oe_a;
  wire        m_we   = s ? we_b : we_a;
  wire        m_en   = s ? en_b : en_a;
  wire [15:0] m_rd   = s ? ifb.rdata : ifa.rdata;
  wire        m_busy = s ? ifb.busy : ifa.busy;
  wire        m_done = s ? ifb.done : ifa.done;
  always @(negedge CLK) if (!RST) begin
    vectors++;
    if ((!oe_a && !we_a) || (!we_a && en_a) || (!oe_b && !we_b) || (!we_b && en_b)) begin
      errors++;
      $display("FAIL strobe_invariant: a oe/we/en=%b%b%b b oe/we/en=%b%b%b", oe_a, we_a, en_a, oe_b, we_b, en_b);
    end
  end
  function automatic int key(input logic sel, input logic [15:0] a);
    return {15'd0, sel, a};
  endfunction
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d, input logic noise);
    int wc = s ? 3 : 1;
    int k, we_n = 0, oe_n = 0, en_n = 0;
    logic [15:0] exp_rd;
    req = 1'b1; wr = w; addr = a; wdata = d;
    @(posedge CLK); #1;
    req = 1'b0;
    exp_rd = w ? last_rd[s] : ref_mem[key(s, a)];
    if (w) ref_mem[key(s, a)] = d;
    for (k = 0; k < 40; k++) begin
      if (noise) begin
        req = 1'($urandom); wr = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
      end
      @(negedge CLK);
      if (m_done) break;
      vectors++;
      if (m_addr !== {2'b00, a} || m_busy !== 1'b1) begin
        errors++;
        $display("FAIL addr_busy k=%0d: addr=%h busy=%b expected addr=%h busy=1", k, m_addr, m_busy, {2'b00, a});
      end
      if (w && !m_en) begin
        vectors++;
        if (m_bus !== d || m_oe !== 1'b1) begin
          errors++;
          $display("FAIL write_bus k=%0d: bus=%h oe=%b expected bus=%h oe=1", k, m_bus, m_oe, d);
        end
      end
      we_n += int'(!m_we); oe_n += int'(!m_oe); en_n += int'(!m_en);
      @(posedge CLK); #1;
    end
    req = 1'b0;
    vectors++;
    if (k !== (w ? wc + 2 : wc + 1)) begin
      errors++;
      $display("FAIL done_latency wr=%b: got %0d cycles expected %0d", w, k, w ? wc + 2 : wc + 1);
    end
    vectors++;
    if (we_n !== (w ? wc : 0) || oe_n !== (w ? 0 : wc + 1) || en_n !== (w ? wc + 2 : wc + 1)) begin
      errors++;
      $display("FAIL strobe_widths wr=%b: we=%0d oe=%0d en=%0d expected we=%0d oe=%0d en=%0d", w, we_n, oe_n, en_n,
        w ? wc : 0, w ? 0 : wc + 1, w ? wc + 2 : wc + 1);
    end
    vectors++;
    if (m_rd !== exp_rd || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL rdata_busy addr=%h: rdata=%h busy=%b expected rdata=%h busy=0", a, m_rd, m_busy, exp_rd);
    end
    last_rd[s] = exp_rd;
  endtask
  task automatic test_reset;
    #2 RST = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      s = i[0]; #1;
      vectors++;
      if ({m_en, m_oe, m_we, m_busy, m_done, m_addr, m_rd} !== {5'b11100, 18'd0, 16'd0}) begin
        errors++;
        $display("FAIL reset_state inst=%0d: en/oe/we/busy/done=%b%b%b%b%b addr=%h rdata=%h expected 11100/0/0",
          i, m_en, m_oe, m_we, m_busy, m_done, m_addr, m_rd);
      end
    end
    @(posedge CLK); #1;
    RST = 1'b0; s = 1'b0;
    last_rd[0] = 16'd0; last_rd[1] = 16'd0;
  endtask
  task automatic test_write_read_w1;
    s = 1'b0;
    access(1'b1, 16'h0005, 16'hA5A5, 1'b0);
    access(1'b0, 16'h0005, 16'h0000, 1'b0);
  endtask
  task automatic test_back_to_back;
    s = 1'b1;
    for (int i = 0; i < 10; i++) access(1'b1, 16'h0100 + 16'(i), 16'(i), 1'b0);
    for (int i = 0; i < 10; i++) access(1'b0, 16'h0100 + 16'(i), 16'h0000, 1'b0);
  endtask
  task automatic test_busy_ignore;
    for (int i = 0; i < 4; i++) begin
      s = i[0];
      access(i[1], 16'h0005 + 16'(i[0]), 16'h1234 + 16'(i), 1'b1);
      repeat (3) begin
        @(negedge CLK);
        vectors++;
        if (m_done !== 1'b0 || m_busy !== 1'b0) begin
          errors++;
          $display("FAIL extra_done inst=%0d: done=%b busy=%b expected 0 0", i[0], m_done, m_busy);
        end
      end
    end
  endtask
  task automatic test_random;
    logic [15:0] a;
    for (int i = 0; i < 24; i++) begin
      s = 1'($urandom_range(0, 1));
      a = 16'h3000 + 16'($urandom_range(0, 7));
      if (!ref_mem.exists(key(s, a)) || $urandom_range(0, 1) == 1)
        access(1'b1, a, 16'($urandom), 1'($urandom_range(0, 1)));
      else
        access(1'b0, a, 16'h0000, 1'($urandom_range(0, 1)));
    end
  endtask
  task automatic test_reset_mid_access;
    s = 1'b1;
    req = 1'b1; wr = 1'b1; addr = 16'h0200; wdata = 16'hBEEF;
    @(posedge CLK); #1;
    req = 1'b0;
    repeat (2) @(negedge CLK);
    vectors++;
    if (m_we !== 1'b0) begin
      errors++;
      $display("FAIL pulse_entry: we=%b expected 0", m_we);
    end
    #2 RST = 1'b1; probe = 1'b1; #1;
    vectors++;
    if ({m_en, m_oe, m_we, m_busy, m_done} !== 5'b11100 || m_bus !== 16'h0000 || m_rd !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: en/oe/we/busy/done=%b%b%b%b%b bus=%h rdata=%h expected 11100 bus released rdata=0000",
        m_en, m_oe, m_we, m_busy, m_done, m_bus, m_rd);
    end
    repeat (3) begin
      @(negedge CLK);
      vectors++;
      if (m_done !== 1'b0 || m_busy !== 1'b0 || ifa.rdata !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold: done=%b busy=%b rdata_a=%h expected 0 0 0000", m_done, m_busy, ifa.rdata);
      end
    end
    @(posedge CLK); #1;
    RST = 1'b0; probe = 1'b0;
    ref_mem.delete(key(1'b1, 16'h0200));
    last_rd[0] = 16'd0; last_rd[1] = 16'd0;
    access(1'b0, 16'h0107, 16'h0000, 1'b0);
  endtask
  initial begin
    test_reset;
    test_write_read_w1;
    test_back_to_back;
    test_busy_ignore;
    test_random;
    test_reset_mid_access;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Request/acknowledge front end for the board's asynchronous 16-bit SRAM (Ram1). It sits directly downstream of the switch-driven test controller. It accepts one word read or write per request, sequences the active-low EN/OE/WE strobes with a programmable access width, owns the tri-state data bus, and returns read data with a one-cycle completion pulse.

## Interface
- WAIT_CYCLES, default 1: width of the WE-low / OE-sample window in clock cycles; legal range 1..15.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- req  in  1  request strobe; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; sampled with req.
- addr  in  16  word address; sampled with req.
- wdata  in  16  write data; sampled with req.
- rdata  out  16  last read word; holds until next read completes.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- Ram1Addr  out  18  SRAM address = {2'b00, latched addr}.
- Ram1Data  inout  16  SRAM data bus; driven only during write phases, else high-Z.
- Ram1OE  out  1  output enable, active low.
- Ram1WE  out  1  write enable, active low.
- Ram1EN  out  1  chip enable, active low.

## Operation
- All outputs registered; no combinational path from req to SRAM pins.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT.
- IDLE: EN=OE=WE=1, bus high-Z, busy=0. On req=1, latch addr/wdata/wr and go to W_SETUP (wr=1) or R_SETUP (wr=0).
- W_SETUP (1 cycle): EN=0, WE=1, OE=1, bus drives latched wdata.
- W_PULSE (WAIT_CYCLES cycles): WE=0, bus driven.
- W_HOLD (1 cycle): WE=1, bus still driven, EN=0. Then go to IDLE and assert done.
- R_SETUP (1 cycle): EN=0, OE=0, bus high-Z.
- R_WAIT (WAIT_CYCLES cycles): EN=0, OE=0. rdata captures Ram1Data on the edge leaving the last R_WAIT cycle. Then go to IDLE and assert done.
- Down-counter (4 bits) loaded with WAIT_CYCLES-1 on entry to W_PULSE/R_WAIT; phase ends when it reads 0.
- Invariants: OE=0 never coincides with bus driven; WE=0 only in W_PULSE; Ram1Addr is stable from SETUP through the end of the access.
- req/wr/addr/wdata are ignored while busy. No queueing; the requester must hold or re-issue req.
- A req seen in the done cycle (FSM in IDLE) is accepted; back-to-back accesses have no dead cycle.

## Timing
- Reset (async, immediate): state=IDLE, EN=OE=WE=1, bus high-Z, Ram1Addr=0, rdata=0x0000, busy=0, done=0, counter=0.
- Acceptance edge = T0. Write: done high in cycle T0+2+WAIT_CYCLES; WE low for exactly WAIT_CYCLES cycles.
- Read: rdata valid and done high in cycle T0+1+WAIT_CYCLES.
- busy rises on T0+1 and falls in the same cycle done rises.
- Reset asserted mid-access: strobes deassert and the bus releases within the same cycle (no clock needed). The aborted access produces no done; a partially completed write leaves SRAM contents undefined at that address.
- Reset release: first req accepted on the first rising edge with RST=0.

## Test plan
- Reset: assert RST mid-W_PULSE -> WE/EN/OE go to 1 and Ram1Data goes to Z without a clock edge; rdata=0, busy=0, no done.
- Write, WAIT_CYCLES=1: req, wr=1, addr=0x0005, wdata=0xA5A5 -> Ram1Addr=0x00005; WE low exactly 1 cycle, bus=0xA5A5 from SETUP through HOLD; done 3 cycles after acceptance.
- Read back with SRAM model: req, wr=0, addr=0x0005 -> OE low 2 cycles, bus high-Z, rdata=0xA5A5, done 2 cycles after acceptance.
- WAIT_CYCLES=3, ten writes at 0x0100..0x0109 with data 0..9 issued back-to-back on done, then ten reads -> each WE pulse 3 cycles, no idle gap, reads return 0..9 in order.
- req toggled while busy with a different addr -> ignored; Ram1Addr stays stable; exactly one done per accepted request.
- Checker throughout: never OE=0 while the bus is driven; never WE=0 outside EN=0.
